// File: rtl/proc_control_fsm.sv
// Moore control unit sequencing the 16-bit datapath through fetch, decode and execute.
// Outputs decode only the current state and IR; no handshakes, so it never stalls.
module proc_control_fsm (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] IR,
   output logic        PC_clr,
   output logic        PC_up,
   output logic        IR_ld,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s0,
   output logic        Illegal,
   output logic        Halted,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] opcode;

   assign opcode = IR[15:12];
   assign State  = state;

   // Strobes are pure state decode, so an asynchronous reset drops them immediately.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = S_INIT;
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = 8'h00;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'h0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = 4'h0;
      RF_Rb_addr = 4'h0;
      ALU_s0     = ALU_PASS;
      Illegal    = 1'b0;
      Halted     = 1'b0;

      case (state)
         S_INIT: begin
            PC_clr    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            IR_ld     = 1'b1;
            PC_up     = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_NOOP:  state_nxt = S_NOOP;
               OP_STORE: state_nxt = S_STORE;
               OP_LOAD:  state_nxt = S_LOAD_A;
               OP_ADD:   state_nxt = S_ADD;
               OP_SUB:   state_nxt = S_SUB;
               OP_HALT:  state_nxt = S_HALT;
               default: begin
                  Illegal   = 1'b1;
                  state_nxt = S_NOOP;
               end
            endcase
         end
         S_NOOP: begin
            state_nxt = S_FETCH;
         end
         // LOAD_A only presents the address; the synchronous memory returns data in LOAD_B.
         S_LOAD_A: begin
            D_addr    = IR[11:4];
            state_nxt = S_LOAD_B;
         end
         S_LOAD_B: begin
            D_addr    = IR[11:4];
            RF_s      = 1'b1;
            RF_W_addr = IR[3:0];
            RF_W_en   = 1'b1;
            state_nxt = S_FETCH;
         end
         S_STORE: begin
            D_addr     = IR[11:4];
            RF_Ra_addr = IR[3:0];
            D_wr       = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_ADD: begin
            RF_Ra_addr = IR[11:8];
            RF_Rb_addr = IR[7:4];
            ALU_s0     = ALU_ADD;
            RF_W_addr  = IR[3:0];
            RF_W_en    = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_SUB: begin
            RF_Ra_addr = IR[11:8];
            RF_Rb_addr = IR[7:4];
            ALU_s0     = ALU_SUB;
            RF_W_addr  = IR[3:0];
            RF_W_en    = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_HALT: begin
            Halted    = 1'b1;
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: a per-cycle vector table through one of each
// instruction, then hand-written HALT hold and asynchronous-reset-in-LOAD_B sequences.
module tb_proc_control_fsm;

   logic        Clk;
   logic        Reset_n;
   logic [15:0] IR;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Illegal, Halted;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
   logic [2:0]  ALU_s0;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] rf_w_addr;
      logic       rf_w_en;
      logic [3:0] rf_ra_addr;
      logic [3:0] rf_rb_addr;
      logic [2:0] alu_s0;
      logic       illegal;
      logic       halted;
   } out_t;

   typedef struct {
      logic        rst_n;
      logic [15:0] ir;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   proc_control_fsm dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .IR         (IR),
      .PC_clr     (PC_clr),
      .PC_up      (PC_up),
      .IR_ld      (IR_ld),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .Illegal    (Illegal),
      .Halted     (Halted),
      .State      (State)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic out_t z(input logic [3:0] st);
      out_t o;
      o       = '0;
      o.state = st;
      if (st == 4'd0) o.pc_clr = 1'b1;
      if (st == 4'd1) begin
         o.ir_ld = 1'b1;
         o.pc_up = 1'b1;
      end
      if (st == 4'd9) o.halted = 1'b1;
      return o;
   endfunction

   function automatic out_t got();
      return {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
              RF_Ra_addr, RF_Rb_addr, ALU_s0, Illegal, Halted};
   endfunction

   task automatic add(input logic r, input logic [15:0] ir, input out_t e);
      vec_t v;
      v.rst_n = r;
      v.ir    = ir;
      v.exp   = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input out_t e);
      out_t g;
      g = got();
      n_cmp++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                  name, g.state, g, e.state, e);
      end
   endtask

   out_t e;

   initial begin
      Reset_n = 1'b0;
      IR      = 16'h0000;

      // Reset, release, then LOAD with a garbage IR during FETCH.
      add(1'b0, 16'h0000, z(4'd0));
      add(1'b0, 16'h0000, z(4'd0));
      add(1'b1, 16'h0000, z(4'd0));
      add(1'b1, 16'hF000, z(4'd1));
      add(1'b1, 16'h21B5, z(4'd2));
      e = z(4'd4); e.d_addr = 8'h1B;
      add(1'b1, 16'h21B5, e);
      e = z(4'd5); e.d_addr = 8'h1B; e.rf_s = 1'b1; e.rf_w_addr = 4'd5; e.rf_w_en = 1'b1;
      add(1'b1, 16'h21B5, e);
      // ADD then SUB
      add(1'b1, 16'h3123, z(4'd1));
      add(1'b1, 16'h3123, z(4'd2));
      e = z(4'd7); e.rf_ra_addr = 4'd1; e.rf_rb_addr = 4'd2; e.rf_w_addr = 4'd3;
      e.rf_w_en = 1'b1; e.alu_s0 = 3'b001;
      add(1'b1, 16'h3123, e);
      add(1'b1, 16'h4123, z(4'd1));
      add(1'b1, 16'h4123, z(4'd2));
      e.state = 4'd8; e.alu_s0 = 3'b010;
      add(1'b1, 16'h4123, e);
      // STORE
      add(1'b1, 16'h1407, z(4'd1));
      add(1'b1, 16'h1407, z(4'd2));
      e = z(4'd6); e.d_addr = 8'h40; e.rf_ra_addr = 4'd7; e.d_wr = 1'b1;
      add(1'b1, 16'h1407, e);
      // Illegal opcode, then HALT
      add(1'b1, 16'hF000, z(4'd1));
      e = z(4'd2); e.illegal = 1'b1;
      add(1'b1, 16'hF000, e);
      add(1'b1, 16'hF000, z(4'd3));
      add(1'b1, 16'h5000, z(4'd1));
      add(1'b1, 16'h5000, z(4'd2));
      add(1'b1, 16'h5000, z(4'd9));

      foreach (vecs[i]) begin
         @(negedge Clk);
         Reset_n = vecs[i].rst_n;
         IR      = vecs[i].ir;
         #1;
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // HALT holds with no PC_up, whatever IR does.
      for (int k = 0; k < 22; k++) begin
         @(negedge Clk);
         IR = 16'h3123 + 16'(k);
         #1;
         chk($sformatf("halt_hold%0d", k), z(4'd9));
      end

      // Reset out of HALT, run to LOAD_B, then reset asynchronously mid-cycle.
      @(negedge Clk); Reset_n = 1'b0; #1; chk("halt_reset", z(4'd0));
      @(negedge Clk); Reset_n = 1'b1; IR = 16'h21B5; #1; chk("lb_init", z(4'd0));
      @(negedge Clk); #1; chk("lb_fetch", z(4'd1));
      @(negedge Clk); #1; chk("lb_decode", z(4'd2));
      e = z(4'd4); e.d_addr = 8'h1B;
      @(negedge Clk); #1; chk("lb_load_a", e);
      e = z(4'd5); e.d_addr = 8'h1B; e.rf_s = 1'b1; e.rf_w_addr = 4'd5; e.rf_w_en = 1'b1;
      @(posedge Clk); #1; chk("lb_load_b", e);
      #2; Reset_n = 1'b0;
      #1; chk("async_reset_in_load_b", z(4'd0));
      @(negedge Clk); Reset_n = 1'b1; IR = 16'h0000; #1; chk("restart_init", z(4'd0));
      @(negedge Clk); #1; chk("restart_fetch", z(4'd1));
      @(negedge Clk); #1; chk("restart_decode", z(4'd2));
      @(negedge Clk); #1; chk("noop_exec", z(4'd3));
      @(negedge Clk); #1; chk("noop_refetch", z(4'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Write strobes must be mutually exclusive on every cycle.
   always @(negedge Clk) begin
      if (Reset_n && D_wr && RF_W_en) begin
         n_fail++;
         $display("FAIL wr_exclusive: D_wr=%b RF_W_en=%b, want not both 1", D_wr, RF_W_en);
      end
   end

endmodule
